// File: rtl/sbox_du_analyzer_if.sv
// Bus between the DDT analyzer and its environment: run control, S-box drive/return, results.
// No flow control: start is a level request, done is a single-cycle strobe.
interface sbox_du_analyzer_if #(
  parameter int N = 6
);
  logic         start;
  logic [N-1:0] sbox_x;
  logic [N-1:0] sbox_y;
  logic         busy;
  logic         done;
  logic [N:0]   du;
  logic [N-1:0] du_a;
  logic [N-1:0] du_b;
  logic         bijective;

  modport master (
    output start, sbox_y,
    input  sbox_x, busy, done, du, du_a, du_b, bijective
  );

  modport slave (
    input  start, sbox_y,
    output sbox_x, busy, done, du, du_a, du_b, bijective
  );
endinterface

// File: rtl/sbox_du_analyzer.sv
// Characterises an external N-bit S-box: differential uniformity, first max (a,b), bijectivity.
// Latency 2^N + (2^N-1)*2^(N+1) busy cycles then a done pulse; no backpressure, start ignored unless idle.
module sbox_du_analyzer #(
  parameter int N = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  sbox_du_analyzer_if.slave bus
);
  localparam int DEPTH = 1 << N;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ACC, S_SCAN, S_DONE} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] idx_q, idx_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] sbox_x_q, sbox_x_d;
  logic [N:0]   du_q, du_d;
  logic [N-1:0] du_a_q, du_a_d;
  logic [N-1:0] du_b_q, du_b_d;
  logic         bij_q, bij_d;

  logic [N-1:0] tbl_q  [DEPTH];
  logic [N:0]   hist_q [DEPTH];

  logic         tbl_we;
  logic         hist_we;
  logic [N-1:0] hist_waddr;
  logic [N:0]   hist_wdat;
  logic [N-1:0] acc_bin;
  logic [N:0]   hist_rd;
  logic         last_idx;

  assign last_idx = &idx_q;
  assign acc_bin  = tbl_q[idx_q] ^ tbl_q[idx_q ^ a_q];
  // One read port serves both the ACC increment and the SCAN compare.
  assign hist_rd  = hist_q[(state_q == S_ACC) ? acc_bin : idx_q];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    du_d       = du_q;
    du_a_d     = du_a_q;
    du_b_d     = du_b_q;
    bij_d      = bij_q;
    tbl_we     = 1'b0;
    hist_we    = 1'b0;
    hist_waddr = idx_q;
    hist_wdat  = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          idx_d   = '0;
          du_d    = '0;
          du_a_d  = '0;
          du_b_d  = '0;
          bij_d   = 1'b1;
        end
      end
      S_LOAD: begin
        tbl_we  = 1'b1;
        hist_we = 1'b1;
        idx_d   = idx_q + 1'b1;
        if (last_idx) begin
          state_d = S_ACC;
          idx_d   = '0;
          a_d     = N'(1);
        end
      end
      S_ACC: begin
        // Write commits at the edge, so a repeated bin next cycle reads the updated count.
        hist_we    = 1'b1;
        hist_waddr = acc_bin;
        hist_wdat  = hist_rd + 1'b1;
        idx_d      = idx_q + 1'b1;
        if (last_idx) begin
          state_d = S_SCAN;
          idx_d   = '0;
        end
      end
      S_SCAN: begin
        if (hist_rd > du_q) begin
          du_d   = hist_rd;
          du_a_d = a_q;
          du_b_d = idx_q;
        end
        if ((idx_q == '0) && (hist_rd != '0)) begin
          bij_d = 1'b0;
        end
        hist_we = 1'b1;
        idx_d   = idx_q + 1'b1;
        if (last_idx) begin
          idx_d = '0;
          if (&a_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ACC;
            a_d     = a_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered drive lines up sbox_x with idx during each LOAD cycle.
    sbox_x_d = (state_d == S_LOAD) ? idx_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      sbox_x_q <= '0;
      du_q     <= '0;
      du_a_q   <= '0;
      du_b_q   <= '0;
      bij_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      sbox_x_q <= sbox_x_d;
      du_q     <= du_d;
      du_a_q   <= du_a_d;
      du_b_q   <= du_b_d;
      bij_q    <= bij_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tbl_q[idx_q] <= bus.sbox_y;
    end
    if (hist_we) begin
      hist_q[hist_waddr] <= hist_wdat;
    end
  end

  assign bus.sbox_x    = sbox_x_q;
  assign bus.busy      = (state_q == S_LOAD) || (state_q == S_ACC) || (state_q == S_SCAN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.du        = du_q;
  assign bus.du_a      = du_a_q;
  assign bus.du_b      = du_b_q;
  assign bus.bijective = bij_q;
endmodule

// File: doc/sbox_du_analyzer.md
# sbox_du_analyzer

Sequential self-test and characterisation stage for a 6-bit S-box in the SMS32 family. It sits on both sides of a combinational S-box instance. It drives the S-box input and captures its output into an internal table. It then sweeps every nonzero input difference, builds each difference-distribution-table (DDT) row in a histogram, and reports the differential uniformity, the first (a, b) pair that reaches it, and whether the S-box is a permutation.

## Interface
- N, default 6: S-box width in bits; table and histogram depth is 2^N.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request a characterisation run; sampled only in IDLE.
- sbox_x  output  N  input applied to the external combinational S-box.
- sbox_y  input  N  S-box output for the current sbox_x, sampled in the same cycle.
- busy  output  1  high while LOAD, ACC or SCAN is active.
- done  output  1  one-cycle pulse when results are valid.
- du  output  N+1  maximum DDT entry over all a≠0 (range 0..2^N).
- du_a  output  N  input difference of the first maximum found.
- du_b  output  N  output difference of the first maximum found.
- bijective  output  1  1 when the S-box is a permutation.

## Operation
- Storage:
  - tbl[2^N] × N bits.
  - hist[2^N] × (N+1) bits; hist has no reset.
  - Counters: idx (N bits) and a (N bits).
- States: IDLE, LOAD, ACC, SCAN, DONE.
- IDLE:
  - sbox_x = 0.
  - On start=1 go to LOAD with idx=0. At the same edge, initialise du=0, du_a=0, du_b=0, bijective=1.
- LOAD, one cycle per idx:
  - sbox_x=idx; tbl[idx]←sbox_y; hist[idx]←0.
  - After idx=2^N−1, go to ACC with a=1 and idx=0.
- ACC, one cycle per x=idx:
  - d = tbl[x] ^ tbl[x^a]; hist[d]←hist[d]+1 as a single-cycle read-modify-write.
  - Repeated d on consecutive cycles must accumulate correctly.
  - After idx=2^N−1, go to SCAN with idx=0.
- SCAN, one cycle per bin b=idx:
  - If hist[b] > du (strictly greater): du←hist[b], du_a←a, du_b←b.
  - If b=0 and hist[0]≠0: bijective←0.
  - Clear hist[b]←0.
  - After b=2^N−1: if a=2^N−1 go to DONE, else a←a+1, idx←0, go to ACC.
- DONE: done=1 for one cycle, then IDLE.
- Ordering: a=0 is never swept. Ties resolve to the smallest a, then the smallest b, in scan order.
- Results (du, du_a, du_b, bijective) hold from DONE until the next accepted start.
- start while not in IDLE is ignored. start held high in IDLE launches back-to-back runs.
- The LOAD phase clears hist, so an aborted run never corrupts the next one.
- No overflow: a DDT entry is at most 2^N, which fits in N+1 bits.

## Timing
- Reset values: all outputs 0, state IDLE, idx=0, a=0.
  - Reset is asynchronous and applies immediately, including mid-run.
  - After reset release no done pulse occurs and results read 0 until a new run completes.
- Let E0 be the edge where start is sampled in IDLE.
  - busy=1 for the 2^N + (2^N−1)·2^(N+1) cycles after E0: 8128 cycles for N=6.
  - done=1 in the next cycle (cycle 8129), with busy=0.
- sbox_x is registered from idx; sbox_y must settle within the same cycle.
- Output registers update only in SCAN and at E0.

## Test plan
- Identity S-box (sbox_y=sbox_x): done on cycle 8129 after E0; du=64, du_a=1, du_b=1, bijective=1.
- Constant S-box (sbox_y=0): du=64, du_a=1, du_b=0, bijective=0.
- Cube map x^3 in GF(2^6), which is APN and not bijective: du=2, bijective=0.
  - du_a and du_b must match a software model's first maximum in scan order.
- Reset pulse at cycle 3000 of a run, then a new start with the identity S-box: no done before the new run; results as in scenario 1, unaffected by stale hist contents.
- start pulsed at cycles 10 and 5000 during a run: both ignored; exactly one done; the next start is accepted only from IDLE.
- start held high across two runs with a random permutation: two done pulses 8130 cycles apart; bijective=1; du even and ≥2; both runs produce identical results.
